// File: rtl/ahb_apb_bridge_n.sv
// rtl/ahb_apb_bridge_n.sv - AHB-Lite slave to N-port APB3 master bridge with slot decoder and response mux (optional APB_TIMEOUT_EN)
module ahb_apb_bridge_n #(
    parameter int NUM_SLAVES     = 16,
    parameter int DEC_LSB        = 20,
    parameter int DEC_W          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HSEL,
    input  logic [31:0]             HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [31:0]             HWDATA,
    input  logic                    HREADY,
    output logic [31:0]             HRDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic [31:0]             PADDR,
    output logic [NUM_SLAVES-1:0]   PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [31:0]             PWDATA,
    input  logic [32*NUM_SLAVES-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]   PREADY,
    input  logic [NUM_SLAVES-1:0]   PSLVERR
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t state, state_nxt;

    logic [DEC_W-1:0]      slot_q;
    logic [DEC_W-1:0]      addr_slot;
    logic                  addr_mapped;
    logic                  can_accept;
    logic                  accept;
    logic                  sel_ready;
    logic                  sel_err;
    logic [31:0]           sel_rdata;
    logic [NUM_SLAVES-1:0] slot_onehot;
    logic                  to_hit;

    assign addr_slot   = HADDR[DEC_LSB +: DEC_W];
    assign addr_mapped = ({1'b0, addr_slot} < (DEC_W+1)'(NUM_SLAVES));
    assign can_accept  = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR2);
    assign accept      = can_accept && HSEL && HREADY && ((HTRANS == 2'b10) || (HTRANS == 2'b11));

    // Response mux and select decode driven only by the registered slot index
    always_comb begin
        sel_ready   = 1'b0;
        sel_err     = 1'b0;
        sel_rdata   = '0;
        slot_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (slot_q == DEC_W'(i)) begin
                sel_ready      = PREADY[i];
                sel_err        = PSLVERR[i];
                sel_rdata      = PRDATA[32*i +: 32];
                slot_onehot[i] = 1'b1;
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    logic [15:0] to_cnt;

    // Wait-cycle counter: cleared while entering ACCESS, counts PREADY-low ACCESS cycles
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            to_cnt <= '0;
        end else if (state == ST_SETUP) begin
            to_cnt <= '0;
        end else if ((state == ST_ACCESS) && !sel_ready) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    assign to_hit = (to_cnt == 16'(TIMEOUT_CYCLES));
`else
    // No timeout hardware; the parameter only keeps the interface identical across builds
    assign to_hit = 1'b0 & (TIMEOUT_CYCLES < 0);
`endif

    // State register
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state bus outputs
    always_comb begin
        state_nxt = state;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        PSEL      = '0;
        PENABLE   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                HRESP = (state == ST_ERR2);
                if (accept) begin
                    state_nxt = addr_mapped ? ST_SETUP : ST_ERR1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                HREADYOUT = 1'b0;
                PSEL      = slot_onehot;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                HREADYOUT = 1'b0;
                PSEL      = slot_onehot;
                PENABLE   = 1'b1;
                if (sel_ready) begin
                    state_nxt = sel_err ? ST_ERR1 : ST_DONE;
                end else if (to_hit) begin
                    state_nxt = ST_ERR1;
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_nxt = ST_ERR2;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Address-phase capture; unmapped accesses leave the APB address untouched
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            slot_q <= '0;
            PADDR  <= '0;
            PWRITE <= 1'b0;
        end else if (accept && addr_mapped) begin
            slot_q <= addr_slot;
            PADDR  <= HADDR;
            PWRITE <= HWRITE;
        end
    end

    // Write data is taken at the end of SETUP, when the AHB data phase is valid
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            PWDATA <= '0;
        end else if (state == ST_SETUP) begin
            PWDATA <= HWDATA;
        end
    end

    // Read data registered on successful completion; writes return zero
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            HRDATA <= '0;
        end else if ((state == ST_ACCESS) && sel_ready && !sel_err) begin
            HRDATA <= PWRITE ? 32'h0 : sel_rdata;
        end
    end

endmodule

// File: doc/ahb_apb_bridge_n.md
Name: ahb_apb_bridge_n

Overview:
- Parametrised AHB-Lite slave to APB master bridge with an integrated N-port address decoder and response mux.
- Successor to the fixed 16-port bridge/bus pair. Adds:
  - a configurable slave count;
  - a configurable decode field;
  - APB3 wait states (PREADY);
  - PSLVERR mapped to a two-cycle AHB ERROR response;
  - an ERROR response for unmapped slots.
- Sits between the AHB interconnect slot and the peripheral APB slaves, such as the I2C, SPI, PWM and timer slaves.

Parameters:
- NUM_SLAVES, 16, number of APB ports (1..16).
- DEC_LSB, 20, lowest HADDR bit of the slot-index field.
- DEC_W, 4, width of the slot-index field; 2**DEC_W >= NUM_SLAVES.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before forced error (APB_TIMEOUT_EN only; 1..65535).

Ports:
- HCLK  in  1  bus clock; also the APB clock.
- HRESET  in  1  asynchronous reset, active-high.
- HSEL  in  1  AHB slot select.
- HADDR  in  32  AHB address.
- HTRANS  in  2  AHB transfer type.
- HWRITE  in  1  AHB write flag.
- HWDATA  in  32  AHB write data.
- HREADY  in  1  AHB bus ready.
- HRDATA  out  32  AHB read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- PADDR  out  32  APB address.
- PSEL  out  NUM_SLAVES  one-hot APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB write.
- PWDATA  out  32  APB write data.
- PRDATA  in  32*NUM_SLAVES  per-slave read data; slave i occupies [32i+31:32i].
- PREADY  in  NUM_SLAVES  per-slave ready.
- PSLVERR  in  NUM_SLAVES  per-slave error.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - State goes to IDLE.
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
- Transfer accept: a transfer is accepted on a rising edge with HSEL & HREADY & HTRANS[1] while in IDLE or DONE. HADDR and HWRITE are registered at that edge; slot = HADDR[DEC_LSB+DEC_W-1:DEC_LSB].
- IDLE/BUSY transfers, or HSEL=0: no APB activity; HREADYOUT=1, HRESP=0.
- States:
  - IDLE: HREADYOUT=1.
    - Mapped accept (slot < NUM_SLAVES) -> SETUP.
    - Unmapped accept -> ERR1.
  - SETUP: PSEL[slot]=1, PENABLE=0, HREADYOUT=0.
    - PWDATA is captured from HWDATA at the end of this cycle. HWDATA is stable because HREADYOUT=0.
    - Always -> ACCESS.
  - ACCESS: PSEL[slot]=1, PENABLE=1, HREADYOUT=0.
    - PREADY[slot]=0: stay.
    - PREADY[slot]=1 and PSLVERR[slot]=0 -> DONE; HRDATA is registered from PRDATA[slot] on reads, and set to 0 on writes.
    - PREADY[slot]=1 and PSLVERR[slot]=1 -> ERR1.
  - DONE: PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0.
    - New accept -> SETUP (or ERR1 if unmapped).
    - Otherwise -> IDLE.
  - ERR1: PSEL=0, HREADYOUT=0, HRESP=1. Always -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Treated as DONE for acceptance of the next transfer. Otherwise -> IDLE.
- Latency with a zero-wait slave: 2 wait states (HREADYOUT low for 2 cycles). Each extra PREADY-low cycle adds 1 wait state.
- PADDR and PWRITE are held from the SETUP cycle until the transfer ends. PADDR and PWDATA keep their last value in IDLE.
- Mux: the PREADY/PSLVERR/PRDATA of deselected slaves are ignored. Only the registered slot index selects the response.
- While PSEL is asserted, a new accept cannot occur because HREADYOUT=0 holds HREADY low. A master violating this is ignored until IDLE/DONE.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY[slot]=0.
  - When count == TIMEOUT_CYCLES and PREADY is still low: PSEL/PENABLE drop and the state goes to ERR1.
  - PREADY=1 on the same cycle as the limit takes priority, giving a normal completion.
- Undefined: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES is unused.

Test Plan:
- Write HADDR=0x0030_0004, data 0xDEADBEEF, slave 3 with PREADY=1 -> PSEL=0x0008 for 2 cycles, PENABLE in the 2nd, PWDATA=0xDEADBEEF, PADDR=0x0030_0004; HREADYOUT low 2 cycles; HRESP=0.
- Read from slave 1 with PREADY low for 3 ACCESS cycles, then high with PRDATA=0x1234_5678 -> HREADYOUT low 5 cycles; HRDATA=0x1234_5678 when HREADYOUT rises.
- Read slave 2 with PREADY=1 and PSLVERR=1 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then IDLE with HRESP=0.
- NUM_SLAVES=4, access to HADDR=0x0050_0000 -> PSEL stays 0; two-cycle ERROR response.
- Back-to-back writes to slaves 0 and 1 (second accepted in DONE) -> second SETUP immediately follows DONE; no IDLE cycle.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and PREADY stuck low -> after 8 ACCESS cycles PSEL drops and ERR1/ERR2 follow. Separately, HRESET asserted mid-ACCESS -> all outputs at reset values immediately.
